// File: rtl/dpram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dpram_arbiter                                                |
// | Description : Round-robin arbiter that grants one of N wvb_reader          |
// |               instances access to a single shared DPRAM. It passes the     |
// |               owner's write port through, holds the buffer for the host,   |
// |               and revokes idle grants.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dpram_arbiter #(
  parameter int N_READERS         = 2,
  parameter int P_DPRAM_ADR_WIDTH = 10,
  parameter int P_GRANT_TIMEOUT   = 64,
  parameter int P_HOLD_CYCLES     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [N_READERS-1:0]                   rdr_req,
  input  logic [N_READERS-1:0]                   rdr_wren,
  input  logic [N_READERS*P_DPRAM_ADR_WIDTH-1:0] rdr_addr,
  input  logic [N_READERS*32-1:0]                rdr_data,
  input  logic [N_READERS-1:0]                   rdr_run,
  input  logic [N_READERS*16-1:0]                rdr_len,
  output logic [N_READERS-1:0]                   rdr_busy,
  output logic                                   dpram_wren,
  output logic [P_DPRAM_ADR_WIDTH-1:0]           dpram_addr,
  output logic [31:0]                            dpram_data,
  output logic [15:0]                            dpram_len,
  output logic [4:0]                             dpram_src,
  output logic                                   dpram_ready,
  input  logic                                   host_done,
  output logic                                   timeout_err,
  output logic                                   illegal_wr_err
);

  localparam int IDX_W = (N_READERS > 1) ? $clog2(N_READERS) : 1;
  localparam int TMO_W = (P_GRANT_TIMEOUT > 1) ? $clog2(P_GRANT_TIMEOUT) : 1;
  localparam int HLD_W = (P_HOLD_CYCLES > 1) ? $clog2(P_HOLD_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_READERS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_GRANT_TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(P_HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]                   state;
  logic [1:0]                   state_next;
  logic [IDX_W-1:0]             own;
  logic [IDX_W-1:0]             last;
  logic [IDX_W-1:0]             sel;
  logic                         sel_found;
  int                           sel_best;
  int                           sel_dist;
  logic [TMO_W-1:0]             tmo_cnt;
  logic [HLD_W-1:0]             hold_cnt;
  logic                         tmo_expired;
  logic                         hold_expired;
  logic [N_READERS-1:0]         own_mask;
  logic                         own_wren;
  logic                         own_run;
  logic [P_DPRAM_ADR_WIDTH-1:0] own_addr;
  logic [31:0]                  own_data;
  logic [15:0]                  own_len;
  logic                         granted;
  logic                         illegal_wr;

  assign granted      = (state == S_FILL) || (state == S_HOLD);
  assign tmo_expired  = (tmo_cnt == TMO_LAST);
  assign hold_expired = (hold_cnt == HLD_LAST);
  assign illegal_wr   = |(rdr_wren & ~(granted ? own_mask : '0));

  // Round-robin pick: the requester closest after 'last' (with wrap) wins.
  always_comb begin
    sel       = last;
    sel_found = 1'b0;
    sel_best  = N_READERS;
    sel_dist  = 0;
    for (int i = 0; i < N_READERS; i++) begin
      sel_dist = (i + N_READERS - int'(last) - 1) % N_READERS;
      if (rdr_req[i] && (sel_dist < sel_best)) begin
        sel_best  = sel_dist;
        sel       = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Multiplex the current owner's signals out of the packed reader buses.
  always_comb begin
    own_mask = '0;
    own_wren = 1'b0;
    own_run  = 1'b0;
    own_addr = '0;
    own_data = '0;
    own_len  = '0;
    for (int i = 0; i < N_READERS; i++) begin
      if (own == IDX_W'(i)) begin
        own_mask[i] = 1'b1;
        own_wren    = rdr_wren[i];
        own_run     = rdr_run[i];
        own_addr    = rdr_addr[i*P_DPRAM_ADR_WIDTH +: P_DPRAM_ADR_WIDTH];
        own_data    = rdr_data[i*32 +: 32];
        own_len     = rdr_len[i*16 +: 16];
      end
    end
  end

  // State register; disabling the block parks it in idle.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a run pulse always beats a write or an expiry.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (sel_found) state_next = S_FILL;
      end
      S_FILL: begin
        if (own_run)                       state_next = S_BUSY;
        else if (!own_wren && tmo_expired) state_next = S_IDLE;
      end
      S_BUSY: begin
        if (host_done) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (own_run)           state_next = S_BUSY;
        else if (own_wren)     state_next = S_FILL;
        else if (hold_expired) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Owner, round-robin pointer, buffer length and the two cycle counters.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      own       <= '0;
      last      <= LAST_RST;
      dpram_len <= '0;
      dpram_src <= '0;
      tmo_cnt   <= '0;
      hold_cnt  <= '0;
    end else begin
      if ((state == S_IDLE) && sel_found) begin
        own       <= sel;
        last      <= sel;
        dpram_src <= 5'(sel);
      end
      if ((state == S_HOLD) && (state_next == S_IDLE)) begin
        last <= own;
      end
      if (granted && own_run) begin
        dpram_len <= own_len;
      end
      // Counters run only inside their own state and sit at zero elsewhere,
      // so every entry into FILL or HOLD starts a fresh count.
      tmo_cnt  <= ((state == S_FILL) && !own_wren) ? tmo_cnt + 1'b1 : '0;
      hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  // Sticky error flags: only rst clears them, and they freeze while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err    <= 1'b0;
      illegal_wr_err <= 1'b0;
    end else if (en) begin
      if (illegal_wr) begin
        illegal_wr_err <= 1'b1;
      end
      if ((state == S_FILL) && !own_run && !own_wren && tmo_expired) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Outputs: busy flags, gated write pass-through and the ready level.
  always_comb begin
    rdr_busy    = granted ? ~own_mask : '1;
    dpram_wren  = granted && own_wren;
    dpram_addr  = own_addr;
    dpram_data  = own_data;
    dpram_ready = (state == S_BUSY);
  end

endmodule
`default_nettype wire

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter N_READERS, default 2: number of wvb_reader instances sharing one DPRAM (1..16).
REQ-002 Parameter P_DPRAM_ADR_WIDTH, default 10: DPRAM address width.
REQ-003 Parameter P_GRANT_TIMEOUT, default 64: cycles without granted-reader activity in S_FILL before the grant is revoked.
REQ-004 Parameter P_HOLD_CYCLES, default 8: cycles the grant is kept in S_HOLD after host completion.
REQ-005 Port clk  in  1: sole clock; all logic SHALL be synchronous to its rising edge.
REQ-006 Port rst  in  1: reset, synchronous, active-high.
REQ-007 Port en  in  1: enable; low SHALL act as reset for the FSM and outputs (the error flags excepted).
REQ-008 Port rdr_req  in  N_READERS: per-reader "header available" (inverted hdr_empty).
REQ-009 Port rdr_wren  in  N_READERS: per-reader DPRAM write enable.
REQ-010 Port rdr_addr  in  N_READERS*P_DPRAM_ADR_WIDTH: per-reader DPRAM address, reader i at bits [i*W +: W].
REQ-011 Port rdr_data  in  N_READERS*32: per-reader DPRAM write data.
REQ-012 Port rdr_run  in  N_READERS: per-reader one-cycle "buffer filled" pulse.
REQ-013 Port rdr_len  in  N_READERS*16: per-reader buffer length; valid with rdr_run.
REQ-014 Port rdr_busy  out  N_READERS: per-reader dpram_busy.
REQ-015 Port dpram_wren / dpram_addr / dpram_data  out  1 / P_DPRAM_ADR_WIDTH / 32: shared DPRAM write port.
REQ-016 Port dpram_len  out  16: registered length of the current buffer.
REQ-017 Port dpram_src  out  5: index of the reader that owns the current buffer.
REQ-018 Port dpram_ready  out  1: level; the buffer is full and readable by the host.
REQ-019 Port host_done  in  1: one-cycle pulse; the host has finished reading the buffer.
REQ-020 Port timeout_err / illegal_wr_err  out  1 / 1: sticky error flags, cleared only by rst.

Function
REQ-021 The FSM SHALL have states S_IDLE, S_FILL, S_BUSY and S_HOLD, with a registered owner index own and a round-robin pointer last.
REQ-022 In S_IDLE, rdr_busy SHALL be all ones, and the FSM SHALL select the first set rdr_req bit, scanning from (last+1) mod N_READERS upward with wrap.
REQ-023 On selection, the FSM SHALL set own and last to the selected index and dpram_src to own, and enter S_FILL on the next cycle; a grant therefore costs 1 cycle from rdr_req.
REQ-024 In S_FILL and S_HOLD, rdr_busy[own] SHALL be 0 and all other bits 1.
REQ-025 In S_BUSY, all rdr_busy bits SHALL be 1.
REQ-026 dpram_wren/addr/data SHALL be a combinational pass-through of reader own, with wren gated to states S_FILL and S_HOLD; in other states dpram_wren SHALL be 0.
REQ-027 A rdr_wren from any non-owner, or from the owner in S_IDLE or S_BUSY, SHALL be dropped and SHALL set illegal_wr_err.
REQ-028 S_FILL: rdr_run[own] SHALL latch dpram_len from rdr_len[own] and enter S_BUSY the next cycle.
REQ-029 S_FILL: the timeout counter SHALL restart on every rdr_wren[own]; when P_GRANT_TIMEOUT cycles elapse with no run, the FSM SHALL set timeout_err and return to S_IDLE.
REQ-030 S_BUSY: dpram_ready SHALL be 1; host_done SHALL clear it and enter S_HOLD on the next cycle; rdr_run in S_BUSY SHALL be ignored.
REQ-031 S_HOLD: the hold counter SHALL count P_HOLD_CYCLES.
REQ-032 S_HOLD: rdr_run[own] SHALL latch dpram_len and enter S_BUSY; rdr_wren[own] SHALL enter S_FILL with the timeout counter cleared; run takes priority if both occur.
REQ-033 S_HOLD: on hold expiry the FSM SHALL return to S_IDLE, with own unchanged and last advanced, so the next grant starts after the old owner.
REQ-034 host_done outside S_BUSY SHALL be ignored.
REQ-035 Simultaneous rdr_req bits SHALL never grant two readers; exactly one owner exists at a time.
REQ-036 Requests arriving while the arbiter is not in S_IDLE SHALL wait; the arbiter SHALL not preempt the current owner.

Reset
REQ-037 On rst or !en, including mid-operation, the FSM SHALL enter S_IDLE.
REQ-038 On rst or !en, the outputs SHALL be: rdr_busy all ones, dpram_wren 0, dpram_ready 0, dpram_len 0, dpram_src 0, own 0, last N_READERS-1 (so reader 0 is served first), and all counters 0.
REQ-039 rst SHALL clear timeout_err and illegal_wr_err; !en SHALL not clear them.

Verification
REQ-040 Scenario: N=2, rdr_req=2'b11 after reset -> reader 0 granted; rdr_busy=2'b10 the next cycle; dpram_src=0.
REQ-041 Scenario: reader 0 writes 4 words, pulses run with len=4, host pulses done; rdr_req=2'b11 throughout -> dpram_len=4; ready high 1 cycle after run; after hold expiry, reader 1 is granted.
REQ-042 Scenario: reader 1 writes during reader 0's S_FILL -> dpram_wren stays 0 for reader 1's writes; illegal_wr_err=1.
REQ-043 Scenario: granted reader idle for 64 cycles -> timeout_err=1 and S_IDLE on cycle 65; the next requester is granted.
REQ-044 Scenario: run pulse at hold cycle 3 -> S_BUSY with no regrant; dpram_src unchanged; dpram_ready=1.
REQ-045 Scenario: rst asserted in S_BUSY -> next cycle dpram_ready=0 and rdr_busy all ones; the errors cleared.
